prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: the CPU core only reads instruction memory, and this block fills a writable instruction memory with a program.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive word addresses starting at 0.
- Holds the CPU in reset through its own active-low reset output until the load completes and the checksum verifies.

Parameters:
ADDR_W, 6, instruction-memory word-address width (matches i_mem_addr)
DATA_W, 32, instruction word width; fixed at 4 bytes

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  block accepts a byte this cycle
i_mem_we  output  1  instruction-memory write enable
i_mem_waddr  output  ADDR_W  write word address
i_mem_wdata  output  DATA_W  write data
cpu_rst_n  output  1  active-low reset to CPU (uc/fd)
busy  output  1  load in progress
done  output  1  last load succeeded (level)
err  output  1  last load had a checksum mismatch (level)

Behaviour:
- Byte transfer: a byte transfers on a rising edge where in_valid=1 and in_ready=1. in_data may change freely when in_ready=0.
- Frame format: header byte H, then 4*(H+1) data bytes, then one checksum byte.
  - H+1 is the word count, range 1..2^ADDR_W; H is interpreted mod 2^ADDR_W, so H=0x3F loads 64 words.
  - Word byte order is little-endian: first byte goes to bits 7:0.
  - Checksum is the XOR of all data bytes; the header is excluded.
- States and transitions:
  - IDLE: start -> LEN.
  - LEN: on byte transfer, latch count=H, clear addr/XOR/byte index -> DATA.
  - DATA: on transfer, shift the byte into the word register and XOR it into the running checksum; after the 4th byte of a word -> WRITE.
  - WRITE: exactly one cycle with i_mem_we=1, i_mem_waddr=addr, i_mem_wdata=assembled word. If addr==count -> CHK, else addr+1 -> DATA.
  - CHK: on transfer, compare the byte to the running XOR. Match -> DONE; mismatch -> ERROR.
  - DONE / ERROR: start -> LEN. Otherwise hold.
- in_ready: 1 in LEN, DATA and CHK; 0 in IDLE, WRITE, DONE and ERROR.
- Throughput: at most 1 word per 5 cycles, because WRITE inserts one bubble.
- cpu_rst_n:
  - 1 in IDLE and DONE.
  - 0 in LEN, DATA, WRITE, CHK and ERROR.
  - Registered; changes on the clock edge after the state change. The CPU therefore leaves reset 1 cycle after entering DONE.
- busy: 1 in LEN, DATA, WRITE and CHK.
- done / err:
  - done=1 only in DONE; err=1 only in ERROR.
  - Both are cleared on entering LEN.
- start handling:
  - Ignored while busy; no restart mid-frame.
  - start coinciding with a byte transfer in DONE or ERROR: the move to LEN is taken and the byte is not consumed, since in_ready=0 in those states.
- i_mem_we is 0 in every state except WRITE. i_mem_waddr and i_mem_wdata hold their last values outside WRITE.
- Reset: rst_n=0 at any time, including mid-frame, asynchronously forces:
  - state=IDLE;
  - cpu_rst_n=0, i_mem_we=0, in_ready=0, busy=0, done=0, err=0;
  - i_mem_waddr=0, i_mem_wdata=0.
  - Partial memory contents are left as written.
  - After release, IDLE drives cpu_rst_n=1 from the next edge, so the CPU runs existing memory.
- Address does not wrap within a frame: the count limit ends the frame before the address overflows.

Test Plan:
1. Single word: start, then bytes 00,93,00,50,00,C3 with in_valid held high -> exactly one i_mem_we pulse with addr=0, data=0x00500093; then done=1, err=0, cpu_rst_n=1 one cycle later.
2. Checksum error: same frame with last byte C2 -> one write to addr 0, err=1, done=0, cpu_rst_n stays 0. A following start plus a correct frame -> done=1.
3. Full memory: H=3F, 256 data bytes where word k = k*0x01010101, correct checksum -> 64 writes to addr 0..63 in order, each with matching data; then done=1.
4. Back-pressure and gaps: random in_valid gaps during the frame, plus in_valid=1 held during WRITE -> no byte lost or duplicated (in_ready=0 in WRITE); memory contents identical to scenario 3.
5. Reset mid-frame: assert rst_n=0 after the 6th data byte -> outputs reach reset values asynchronously and word 0 stays written. After release, cpu_rst_n=1 and busy=0; a fresh frame loads correctly.
6. Start ignored while busy: pulse start during DATA -> no state change and frame completes normally. start in IDLE with H=01 (2 words) -> writes to addr 0 and 1 only.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader filling instruction memory
// Frame: header H, 4*(H+1) little-endian data bytes, XOR checksum byte.
module prog_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              i_mem_we,
  output logic [ADDR_W-1:0] i_mem_waddr,
  output logic [DATA_W-1:0] i_mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   count;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          xsum;
  logic [1:0]          bidx;
  logic [DATA_W-1:0]   word;
  logic                xfer;
  logic [DATA_W-1:0]   word_next;

  assign xfer      = in_valid && in_ready;
  // New bytes enter at the top so the first byte of a word ends in bits 7:0.
  assign word_next = {in_data, word[DATA_W-1:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      addr        <= '0;
      xsum        <= '0;
      bidx        <= '0;
      word        <= '0;
      in_ready    <= 1'b0;
      i_mem_we    <= 1'b0;
      i_mem_waddr <= '0;
      i_mem_wdata <= '0;
      cpu_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // CPU reset follows the state with one cycle of lag.
      cpu_rst_n <= (state == S_IDLE) || (state == S_DONE);
      i_mem_we  <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_LEN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            count <= in_data[ADDR_W-1:0];
            addr  <= '0;
            xsum  <= '0;
            bidx  <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word <= word_next;
            xsum <= xsum ^ in_data;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              state       <= S_WRITE;
              in_ready    <= 1'b0;
              i_mem_we    <= 1'b1;
              i_mem_waddr <= addr;
              i_mem_wdata <= word_next;
            end
          end
        end
        S_WRITE: begin
          in_ready <= 1'b1;
          if (addr == count) begin
            state <= S_CHK;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_DATA;
          end
        end
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == xsum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
